// File: rtl/move_scheduler_pkg.sv
// Shared types for the sprite move scheduler: state encoding, direction codes,
// screen limits and the fixed-priority direction picker.
package move_scheduler_pkg;

    localparam int unsigned SCREEN_X_MAX = 159;
    localparam int unsigned SCREEN_Y_MAX = 119;
    localparam int unsigned X_W          = 8;
    localparam int unsigned Y_W          = 7;

    // One-hot so the state register doubles as the LED display value.
    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_WAIT_TICK = 6'b000010,
        ST_ERASE     = 6'b000100,
        ST_STEP      = 6'b001000,
        ST_DRAW      = 6'b010000,
        ST_DONE      = 6'b100000
    } state_e;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_RIGHT = 3'd1,
        DIR_LEFT  = 3'd2,
        DIR_DOWN  = 3'd3,
        DIR_UP    = 3'd4
    } dir_e;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pos_t;

    // Lowest request bit wins: right > left > down > up.
    function automatic dir_e pick_dir(input logic [3:0] req);
        dir_e d;
        d = DIR_NONE;
        if (req[0])      d = DIR_RIGHT;
        else if (req[1]) d = DIR_LEFT;
        else if (req[2]) d = DIR_DOWN;
        else if (req[3]) d = DIR_UP;
        return d;
    endfunction

endpackage

// File: rtl/move_scheduler_tick_divider.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks.
module tick_divider #(
    parameter int unsigned TICK_DIV = 5000000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == '0) ? RELOAD : cnt_q - CNT_W'(1);
        tick_d = (cnt_d == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= RELOAD;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/move_scheduler.sv
// Tick-paced sprite mover: erases the sprite, steps one pixel in the latched
// direction with edge saturation, redraws it, then pulses move_done.
module move_scheduler
    import move_scheduler_pkg::*;
#(
    parameter int unsigned TICK_DIV = 5000000,
    parameter int unsigned X_MAX    = SCREEN_X_MAX,
    parameter int unsigned Y_MAX    = SCREEN_Y_MAX,
    parameter int unsigned X_INIT   = 80,
    parameter int unsigned Y_INIT   = 60
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [3:0]     dir_req,
    input  logic           halt,
    input  logic           draw_ready,
    output logic           draw_valid,
    output logic           draw_erase,
    output logic [X_W-1:0] xout,
    output logic [Y_W-1:0] yout,
    output logic           busy,
    output logic           move_done,
    output logic [5:0]     state_led
);

    localparam pos_t POS_INIT = '{x: X_W'(X_INIT), y: Y_W'(Y_INIT)};

    logic   tick;
    state_e state_q, state_d;
    dir_e   dir_q, dir_d;
    pos_t   pos_q, pos_d;
    logic   dv_q, dv_d;
    logic   de_q, de_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_NONE;
            pos_q   <= POS_INIT;
            dv_q    <= 1'b0;
            de_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            dv_q    <= dv_d;
            de_q    <= de_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state and position; outputs are decoded from the next state so they
    // register in step with the state they belong to.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pos_d   = pos_q;

        unique case (state_q)
            ST_IDLE: begin
                if (dir_req != 4'b0000) begin
                    dir_d   = pick_dir(dir_req);
                    state_d = ST_WAIT_TICK;
                end
            end
            ST_WAIT_TICK: begin
                if (halt) begin
                    dir_d   = DIR_NONE;
                    state_d = ST_IDLE;
                end else if (tick) begin
                    state_d = ST_ERASE;
                end
            end
            ST_ERASE: begin
                if (dv_q && draw_ready) state_d = ST_STEP;
            end
            ST_STEP: begin
                unique case (dir_q)
                    DIR_RIGHT: if (pos_q.x != X_W'(X_MAX)) pos_d.x = pos_q.x + X_W'(1);
                    DIR_LEFT:  if (pos_q.x != '0)          pos_d.x = pos_q.x - X_W'(1);
                    DIR_DOWN:  if (pos_q.y != Y_W'(Y_MAX)) pos_d.y = pos_q.y + Y_W'(1);
                    DIR_UP:    if (pos_q.y != '0)          pos_d.y = pos_q.y - Y_W'(1);
                    default:   pos_d = pos_q;
                endcase
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                if (dv_q && draw_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (halt) begin
                    dir_d   = DIR_NONE;
                    state_d = ST_IDLE;
                end else if (dir_req != 4'b0000) begin
                    dir_d   = pick_dir(dir_req);
                    state_d = ST_WAIT_TICK;
                end else begin
                    dir_d   = DIR_NONE;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                dir_d   = DIR_NONE;
                state_d = ST_IDLE;
            end
        endcase

        dv_d   = (state_d == ST_ERASE) || (state_d == ST_DRAW);
        de_d   = (state_d == ST_ERASE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign draw_valid = dv_q;
    assign draw_erase = de_q;
    assign xout       = pos_q.x;
    assign yout       = pos_q.y;
    assign busy       = busy_q;
    assign move_done  = done_q;
    assign state_led  = state_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with TICK_DIV=4.
module tb_move_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] dir_req;
    logic       halt;
    logic       draw_ready;
    logic       draw_valid;
    logic       draw_erase;
    logic [7:0] xout;
    logic [6:0] yout;
    logic       busy;
    logic       move_done;
    logic [5:0] state_led;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] L_IDLE  = 6'b000001;
    localparam logic [5:0] L_WAIT  = 6'b000010;
    localparam logic [5:0] L_ERASE = 6'b000100;
    localparam logic [5:0] L_STEP  = 6'b001000;
    localparam logic [5:0] L_DRAW  = 6'b010000;
    localparam logic [5:0] L_DONE  = 6'b100000;

    move_scheduler #(
        .TICK_DIV (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dir_req    (dir_req),
        .halt       (halt),
        .draw_ready (draw_ready),
        .draw_valid (draw_valid),
        .draw_erase (draw_erase),
        .xout       (xout),
        .yout       (yout),
        .busy       (busy),
        .move_done  (move_done),
        .state_led  (state_led)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        dir_req    = 4'b0000;
        halt       = 1'b0;
        draw_ready = 1'b0;
        step_clk();
        step_clk();
        reset = 1'b0;
    endtask

    task automatic wait_dv(input int budget, output int n);
        n = 0;
        while (!draw_valid && n < budget) begin
            step_clk();
            n++;
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!move_done && n < budget) begin
            step_clk();
            n++;
        end
    endtask

    initial begin
        int n;
        int bad;
        int erases, draws, dones, xbad;

        // Reset values
        reset = 1'b1; dir_req = 4'b0000; halt = 1'b0; draw_ready = 1'b0;
        #12;
        check_eq("rst_led",  32'(state_led), 32'(L_IDLE));
        check_eq("rst_x",    32'(xout), 32'd80);
        check_eq("rst_y",    32'(yout), 32'd60);
        check_eq("rst_dv",   32'(draw_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(move_done), 32'd0);

        // Single right move, then the next move waits for the following tick
        apply_reset();
        dir_req = 4'b0001; draw_ready = 1'b1;
        step_clk();
        check_eq("r_wait_led", 32'(state_led), 32'(L_WAIT));
        check_eq("r_wait_busy", 32'(busy), 32'd1);
        wait_dv(12, n);
        check_eq("r_erase_dv", 32'(draw_valid), 32'd1);
        check_eq("r_erase_de", 32'(draw_erase), 32'd1);
        check_eq("r_erase_xy", {24'd0, xout}, 32'd80);
        check_eq("r_erase_y",  32'(yout), 32'd60);
        step_clk();
        check_eq("r_step_led", 32'(state_led), 32'(L_STEP));
        check_eq("r_step_dv",  32'(draw_valid), 32'd0);
        step_clk();
        check_eq("r_draw_led", 32'(state_led), 32'(L_DRAW));
        check_eq("r_draw_de",  32'(draw_erase), 32'd0);
        check_eq("r_draw_x",   32'(xout), 32'd81);
        check_eq("r_draw_y",   32'(yout), 32'd60);
        step_clk();
        check_eq("r_done_md",  32'(move_done), 32'd1);
        check_eq("r_done_dv",  32'(draw_valid), 32'd0);
        wait_dv(12, n);
        check_eq("r_tick_gap", 32'(n), 32'd5);
        check_eq("r_next_x",   32'(xout), 32'd81);
        dir_req = 4'b0000;
        wait_done(12);
        check_eq("r_next_md",  32'(move_done), 32'd1);
        check_eq("r_next_x2",  32'(xout), 32'd82);
        step_clk();
        check_eq("r_idle_led", 32'(state_led), 32'(L_IDLE));
        check_eq("r_idle_busy", 32'(busy), 32'd0);

        // Left beats down; direction stays latched after dir_req drops
        apply_reset();
        dir_req = 4'b0110; draw_ready = 1'b1;
        wait_dv(12, n);
        check_eq("p_erase_x", 32'(xout), 32'd80);
        dir_req = 4'b0000;
        step_clk();
        step_clk();
        check_eq("p_draw_x", 32'(xout), 32'd79);
        check_eq("p_draw_y", 32'(yout), 32'd60);
        step_clk();
        check_eq("p_done_md", 32'(move_done), 32'd1);
        step_clk();
        check_eq("p_idle_led", 32'(state_led), 32'(L_IDLE));

        // Left boundary: walk to x=0, then three saturated moves
        apply_reset();
        dir_req = 4'b0010; draw_ready = 1'b1;
        n = 0;
        while (!(move_done && xout == 8'd0) && n < 3000) begin
            step_clk();
            n++;
        end
        check_eq("b_reach_x0", 32'(move_done && xout == 8'd0), 32'd1);
        erases = 0; draws = 0; dones = 0; xbad = 0; n = 0;
        while (dones < 3 && n < 100) begin
            step_clk();
            n++;
            if (draw_valid && draw_erase && draw_ready)  erases++;
            if (draw_valid && !draw_erase && draw_ready) draws++;
            if (move_done) dones++;
            if (xout != 8'd0 || yout != 7'd60) xbad++;
        end
        dir_req = 4'b0000;
        check_eq("b_erases", 32'(erases), 32'd3);
        check_eq("b_draws",  32'(draws), 32'd3);
        check_eq("b_dones",  32'(dones), 32'd3);
        check_eq("b_xstuck", 32'(xbad), 32'd0);
        step_clk();
        check_eq("b_idle_led", 32'(state_led), 32'(L_IDLE));

        // Backpressure in ERASE with halt held; halt only takes effect at DONE
        apply_reset();
        dir_req = 4'b0001; draw_ready = 1'b0;
        wait_dv(12, n);
        check_eq("h_erase_dv", 32'(draw_valid), 32'd1);
        halt = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step_clk();
            if (!draw_valid || !draw_erase || xout != 8'd80 || yout != 7'd60) bad++;
        end
        check_eq("h_hold_stable", 32'(bad), 32'd0);
        check_eq("h_hold_led", 32'(state_led), 32'(L_ERASE));
        draw_ready = 1'b1;
        step_clk();
        check_eq("h_step_led", 32'(state_led), 32'(L_STEP));
        step_clk();
        check_eq("h_draw_x",  32'(xout), 32'd81);
        check_eq("h_draw_dv", 32'(draw_valid), 32'd1);
        step_clk();
        check_eq("h_done_md", 32'(move_done), 32'd1);
        step_clk();
        check_eq("h_idle_led", 32'(state_led), 32'(L_IDLE));
        halt = 1'b0;

        // Asynchronous reset in the middle of a stalled DRAW
        apply_reset();
        dir_req = 4'b0001; draw_ready = 1'b1;
        wait_dv(12, n);
        step_clk();
        draw_ready = 1'b0;
        step_clk();
        dir_req = 4'b0000;
        check_eq("a_draw_led", 32'(state_led), 32'(L_DRAW));
        check_eq("a_draw_x",   32'(xout), 32'd81);
        #2 reset = 1'b1;
        #1;
        check_eq("a_rst_dv",   32'(draw_valid), 32'd0);
        check_eq("a_rst_de",   32'(draw_erase), 32'd0);
        check_eq("a_rst_led",  32'(state_led), 32'(L_IDLE));
        check_eq("a_rst_x",    32'(xout), 32'd80);
        check_eq("a_rst_y",    32'(yout), 32'd60);
        check_eq("a_rst_busy", 32'(busy), 32'd0);
        step_clk();
        reset = 1'b0;

        // halt in the same cycle as a tick: tick is high in the cycle after the
        // third edge following reset release, so WAIT_TICK sees both at edge 4
        apply_reset();
        dir_req = 4'b0001; draw_ready = 1'b1;
        step_clk();
        check_eq("t_wait_led", 32'(state_led), 32'(L_WAIT));
        step_clk();
        step_clk();
        check_eq("t_wait2_led", 32'(state_led), 32'(L_WAIT));
        halt = 1'b1; dir_req = 4'b0000;
        step_clk();
        halt = 1'b0;
        check_eq("t_halt_led", 32'(state_led), 32'(L_IDLE));
        check_eq("t_halt_dv",  32'(draw_valid), 32'd0);
        check_eq("t_halt_x",   32'(xout), 32'd80);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step_clk();
            if (draw_valid || busy) bad++;
        end
        check_eq("t_stay_idle", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 5000000, clock cycles between movement ticks (0.1 s at 50 MHz).
REQ-002 Parameter X_MAX, default 159, largest legal x coordinate.
REQ-003 Parameter Y_MAX, default 119, largest legal y coordinate.
REQ-004 Parameter X_INIT, default 80, x position after reset.
REQ-005 Parameter Y_INIT, default 60, y position after reset.
REQ-006 clock  in  1  single system clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 dir_req  in  4  direction request: bit0 right, bit1 left, bit2 down, bit3 up.
REQ-009 halt  in  1  stop request; returns the block to IDLE at the next legal point.
REQ-010 draw_ready  in  1  pixel drawer can accept a command.
REQ-011 draw_valid  out  1  command to the drawer is presented.
REQ-012 draw_erase  out  1  1 = erase pixel at xout/yout; 0 = draw pixel there.
REQ-013 xout  out  8  current sprite x coordinate.
REQ-014 yout  out  7  current sprite y coordinate.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 move_done  out  1  one-cycle pulse when a move completes.
REQ-017 state_led  out  6  one-hot copy of the current state for LEDR display.

Function
REQ-018 The tick counter SHALL be free-running: it loads TICK_DIV-1, decrements each cycle, and emits a one-cycle tick when it reaches 0, then reloads.
REQ-019 The FSM SHALL have states IDLE, WAIT_TICK, ERASE, STEP, DRAW and DONE, with state_led bits 0..5 in that order.
REQ-020 IDLE: if any dir_req bit is set, latch one direction by fixed priority (bit0 > bit1 > bit2 > bit3) and go to WAIT_TICK; otherwise stay.
REQ-021 WAIT_TICK: halt=1 goes to IDLE (halt wins over a same-cycle tick); otherwise tick goes to ERASE; otherwise stay.
REQ-022 ERASE: draw_valid=1 and draw_erase=1 at the current position; on draw_valid&&draw_ready go to STEP.
REQ-023 STEP: one cycle; apply the latched direction by ±1 and go to DRAW.
- right: x+1, saturating at X_MAX.
- left: x-1, saturating at 0.
- down: y+1, saturating at Y_MAX.
- up: y-1, saturating at 0.
REQ-024 At a boundary the position SHALL stay unchanged and the erase/draw pair SHALL still complete.
REQ-025 DRAW: draw_valid=1 and draw_erase=0 at the new position; on handshake go to DONE.
REQ-026 DONE: move_done=1 for exactly this cycle.
- halt=1: go to IDLE.
- else dir_req nonzero: relatch direction by priority and go to WAIT_TICK.
- else: go to IDLE.
REQ-027 Once asserted, draw_valid SHALL stay high, with xout, yout and draw_erase stable, until accepted. halt SHALL NOT abort ERASE or DRAW.
REQ-028 Ticks arriving outside WAIT_TICK SHALL be ignored; they are not queued.
REQ-029 The latched direction SHALL NOT change between WAIT_TICK entry and DONE, regardless of dir_req.
REQ-030 draw_valid SHALL be low in IDLE, WAIT_TICK, STEP and DONE. draw_erase SHALL be 0 whenever draw_valid is 0.

Reset
REQ-031 On reset assertion, regardless of clock or state (including mid-handshake), the block SHALL immediately take its reset values:
- state IDLE, state_led 000001;
- xout X_INIT, yout Y_INIT;
- draw_valid, draw_erase, busy and move_done all 0;
- tick counter at TICK_DIV-1;
- latched direction cleared.

Structure
REQ-032 A shared package SHALL hold the state encoding, the direction codes (NONE, RIGHT, LEFT, DOWN, UP) and the default screen limits (X_MAX, Y_MAX).
REQ-033 The tick counter SHALL be a separate sub-module, tick_divider, with parameter TICK_DIV and ports clock, reset and tick. All other logic stays in move_scheduler.

Verification (TICK_DIV=4)
REQ-034 Reset, then dir_req=0001 with draw_ready=1 -> sequence ERASE(80,60), DRAW(81,60), move_done pulse; next move begins only after the next tick.
REQ-035 dir_req=0110 -> left wins over down; x goes 80->79 and y stays 60.
REQ-036 Start at x=0 with left held for three ticks -> xout stays 0; three erase/draw pairs and three move_done pulses occur.
REQ-037 draw_ready held 0 for 10 cycles during ERASE while halt=1 -> draw_valid stays high with coordinates stable; after acceptance the move completes, then the FSM goes to IDLE.
REQ-038 Reset asserted mid-DRAW -> same cycle draw_valid=0, state_led=000001, position (80,60).
REQ-039 halt=1 in the same cycle as a tick in WAIT_TICK -> FSM goes to IDLE with no draw_valid and position unchanged.
